// File: rtl/bp_me_mem_cmd_arbiter_if.sv
// bp_me_mem_cmd_arbiter_if: command/response bundle shared by two requesters, the arbiter and bp_mem.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface bp_me_mem_cmd_arbiter_if #(parameter int msg_width_p = 512);
   logic [msg_width_p-1:0] cmd0_i, cmd1_i, resp0_o, resp1_o, mem_cmd_o, mem_resp_i;
   logic cmd0_v_i, cmd0_ready_o, cmd1_v_i, cmd1_ready_o;
   logic resp0_v_o, resp0_yumi_i, resp1_v_o, resp1_yumi_i;
   logic mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o;
   modport slave (
      input  cmd0_i, cmd0_v_i, cmd1_i, cmd1_v_i, resp0_yumi_i, resp1_yumi_i,
             mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
      output cmd0_ready_o, cmd1_ready_o, resp0_o, resp0_v_o, resp1_o, resp1_v_o,
             mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
   );
   modport master (
      output cmd0_i, cmd0_v_i, cmd1_i, cmd1_v_i, resp0_yumi_i, resp1_yumi_i,
             mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
      input  cmd0_ready_o, cmd1_ready_o, resp0_o, resp0_v_o, resp1_o, resp1_v_o,
             mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
   );
endinterface

// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: round-robin sharing of one bp_mem port between two requesters,
// with responses routed back in issue order through a FIFO of requester IDs.
module bp_me_mem_cmd_arbiter #(
   parameter int msg_width_p = 512,
   parameter int max_outstanding_p = 4,
   localparam int lg_outstanding_lp = $clog2(max_outstanding_p+1)
) (
   input  logic clk_i,
   input  logic reset_n_i,
   bp_me_mem_cmd_arbiter_if.slave io,
   output logic [lg_outstanding_lp-1:0] outstanding_o,
   output logic err_o
);
   localparam int ptr_w_lp = max_outstanding_p > 1 ? $clog2(max_outstanding_p) : 1;
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(max_outstanding_p-1);
   logic [max_outstanding_p-1:0] id_q, id_d;
   logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [lg_outstanding_lp-1:0] cnt_q, cnt_d;
   logic err_q, err_d, last_grant_q, last_grant_d, lock_q, lock_d, locked_id_q, locked_id_d;
   logic empty, full, grant, rdy, hs, head, resp_v, pop, bad_yumi;
   logic [msg_width_p-1:0] cmd_sel;
   assign empty = cnt_q == '0;
   assign full = cnt_q == lg_outstanding_lp'(max_outstanding_p);
   // A stalled command keeps its grant so memory sees a stable request until accepted.
   assign grant = lock_q ? locked_id_q : (io.cmd0_v_i & io.cmd1_v_i) ? ~last_grant_q : io.cmd1_v_i;
   assign cmd_sel = grant ? io.cmd1_i : io.cmd0_i;
   assign rdy = reset_n_i & io.mem_cmd_ready_i & ~full;
   assign io.mem_cmd_o = cmd_sel;
   assign io.mem_cmd_v_o = reset_n_i & ~full & (grant ? io.cmd1_v_i : io.cmd0_v_i);
   assign io.cmd0_ready_o = rdy & ~grant;
   assign io.cmd1_ready_o = rdy & grant;
   assign hs = io.mem_cmd_v_o & io.mem_cmd_ready_i;
   assign head = id_q[rptr_q];
   assign resp_v = reset_n_i & io.mem_resp_v_i & ~empty;
   assign io.resp0_o = io.mem_resp_i;
   assign io.resp1_o = io.mem_resp_i;
   assign io.resp0_v_o = resp_v & ~head;
   assign io.resp1_v_o = resp_v & head;
   assign pop = head ? io.resp1_yumi_i & io.resp1_v_o : io.resp0_yumi_i & io.resp0_v_o;
   assign io.mem_resp_yumi_o = pop;
   assign bad_yumi = resp_v & (head ? io.resp0_yumi_i : io.resp1_yumi_i);
   assign outstanding_o = cnt_q;
   assign err_o = err_q;
   always_comb begin
      id_d = id_q;
      if (hs) id_d[wptr_q] = grant;
      wptr_d = hs ? (wptr_q == last_ptr_lp ? '0 : wptr_q + 1'b1) : wptr_q;
      rptr_d = pop ? (rptr_q == last_ptr_lp ? '0 : rptr_q + 1'b1) : rptr_q;
      cnt_d = cnt_q + lg_outstanding_lp'(hs) - lg_outstanding_lp'(pop);
      err_d = err_q | (io.mem_resp_v_i & empty) | bad_yumi;
      last_grant_d = hs ? grant : last_grant_q;
      lock_d = hs ? 1'b0 : (io.mem_cmd_v_o | lock_q);
      locked_id_d = (io.mem_cmd_v_o & ~hs) ? grant : locked_id_q;
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         id_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
         last_grant_q <= 1'b1;
         lock_q <= 1'b0;
         locked_id_q <= 1'b0;
      end else begin
         id_q <= id_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         last_grant_q <= last_grant_d;
         lock_q <= lock_d;
         locked_id_q <= locked_id_d;
      end
endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb_bp_me_mem_cmd_arbiter: directed bench for the two-requester memory arbiter.
// Expected response owner/data are queued at issue time and popped when memory responds.
module tb_bp_me_mem_cmd_arbiter;
   typedef struct packed {logic id; logic [31:0] data;} exp_t;
   logic clk_i = 1'b0;
   logic reset_n_i;
   logic [2:0] outstanding;
   logic err;
   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   bp_me_mem_cmd_arbiter_if #(.msg_width_p(32)) bus();
   bp_me_mem_cmd_arbiter #(.msg_width_p(32), .max_outstanding_p(4)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .io(bus), .outstanding_o(outstanding), .err_o(err)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask
   task automatic idle();
      bus.cmd0_v_i = 1'b0;
      bus.cmd1_v_i = 1'b0;
   endtask
   task automatic issue(input logic v0, input logic v1, input logic g, input int n);
      logic [31:0] d0, d1;
      d0 = 32'hA000_0000 | n;
      d1 = 32'hB000_0000 | n;
      bus.cmd0_v_i = v0;
      bus.cmd1_v_i = v1;
      bus.cmd0_i = d0;
      bus.cmd1_i = d1;
      bus.mem_cmd_ready_i = 1'b1;
      #1;
      chk("issue_v", bus.mem_cmd_v_o, 1);
      chk("issue_data", bus.mem_cmd_o, g ? d1 : d0);
      chk("issue_rdy", {bus.cmd1_ready_o, bus.cmd0_ready_o}, g ? 2'b10 : 2'b01);
      sb.push_back('{id: g, data: g ? d1 : d0});
      tick();
   endtask
   task automatic resp_drive();
      exp_t e;
      e = sb.pop_front();
      bus.mem_resp_v_i = 1'b1;
      bus.mem_resp_i = e.data ^ 32'h0F0F_0F0F;
      bus.resp0_yumi_i = ~e.id;
      bus.resp1_yumi_i = e.id;
      #1;
      chk("resp_v", {bus.resp1_v_o, bus.resp0_v_o}, e.id ? 2'b10 : 2'b01);
      chk("resp_data", e.id ? bus.resp1_o : bus.resp0_o, e.data ^ 32'h0F0F_0F0F);
      chk("resp_yumi", bus.mem_resp_yumi_o, 1);
   endtask
   task automatic resp_clear();
      bus.mem_resp_v_i = 1'b0;
      bus.resp0_yumi_i = 1'b0;
      bus.resp1_yumi_i = 1'b0;
   endtask
   task automatic respond();
      resp_drive();
      tick();
      resp_clear();
   endtask
   initial begin
      reset_n_i = 1'b0;
      bus.cmd0_i = '0;
      bus.cmd1_i = '0;
      bus.mem_resp_i = '0;
      idle();
      resp_clear();
      bus.mem_cmd_ready_i = 1'b0;
      #1;
      bus.cmd0_v_i = 1'b1;
      bus.cmd1_v_i = 1'b1;
      bus.mem_cmd_ready_i = 1'b1;
      bus.mem_resp_v_i = 1'b1;
      #1;
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err, 0);
      chk("rst_v_rdy", {bus.mem_cmd_v_o, bus.cmd0_ready_o, bus.cmd1_ready_o,
                        bus.resp0_v_o, bus.resp1_v_o, bus.mem_resp_yumi_o}, 0);
      idle();
      resp_clear();
      tick();
      tick();
      reset_n_i = 1'b1;
      tick();
      // single requester, three back-to-back issues then drain
      for (int k = 0; k < 3; k++) begin
         issue(1'b1, 1'b0, 1'b0, k);
         chk("t1_outstanding_up", outstanding, k + 1);
      end
      idle();
      tick();
      for (int k = 0; k < 3; k++) begin
         respond();
         chk("t1_outstanding_down", outstanding, 2 - k);
      end
      // both requesters valid: alternation from reset, saturation at 4
      reset_n_i = 1'b0;
      #1;
      reset_n_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         issue(1'b1, 1'b1, k[0], k);
         chk("t2_outstanding", outstanding, k + 1);
      end
      #1;
      chk("t2_full_block", {bus.mem_cmd_v_o, bus.cmd1_ready_o, bus.cmd0_ready_o}, 0);
      resp_drive();
      chk("t2_full_retire_block", {bus.mem_cmd_v_o, bus.cmd1_ready_o, bus.cmd0_ready_o}, 0);
      tick();
      resp_clear();
      chk("t2_after_retire", outstanding, 3);
      issue(1'b1, 1'b1, 1'b0, 4);
      chk("t2_refill", outstanding, 4);
      idle();
      for (int k = 0; k < 4; k++) respond();
      chk("t2_drained", outstanding, 0);
      // lone cmd1 leaves last_grant=1 so an unlocked tie would pick cmd0
      issue(1'b0, 1'b1, 1'b1, 5);
      idle();
      respond();
      bus.mem_cmd_ready_i = 1'b0;
      bus.cmd1_i = 32'hB000_0006;
      bus.cmd0_i = 32'hA000_0006;
      bus.cmd1_v_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) bus.cmd0_v_i = 1'b1;
         #1;
         chk("t3_lock_v", bus.mem_cmd_v_o, 1);
         chk("t3_lock_data", bus.mem_cmd_o, 32'hB000_0006);
         chk("t3_lock_rdy", {bus.cmd1_ready_o, bus.cmd0_ready_o}, 0);
         tick();
      end
      bus.mem_cmd_ready_i = 1'b1;
      #1;
      chk("t3_accept_rdy", {bus.cmd1_ready_o, bus.cmd0_ready_o}, 2'b10);
      chk("t3_accept_data", bus.mem_cmd_o, 32'hB000_0006);
      sb.push_back('{id: 1'b1, data: 32'hB000_0006});
      tick();
      issue(1'b1, 1'b0, 1'b0, 6);
      idle();
      respond();
      respond();
      // issue order 0,1,1,0; head owner withholds yumi first
      issue(1'b1, 1'b0, 1'b0, 7);
      issue(1'b0, 1'b1, 1'b1, 8);
      issue(1'b0, 1'b1, 1'b1, 9);
      issue(1'b1, 1'b0, 1'b0, 10);
      idle();
      bus.mem_resp_v_i = 1'b1;
      bus.mem_resp_i = 32'h1234_5678;
      #1;
      chk("t4_hold_v", {bus.resp1_v_o, bus.resp0_v_o}, 2'b01);
      chk("t4_hold_yumi", bus.mem_resp_yumi_o, 0);
      tick();
      resp_clear();
      chk("t4_hold_outstanding", outstanding, 4);
      for (int k = 0; k < 4; k++) respond();
      chk("t4_no_err", err, 0);
      chk("t4_drained", outstanding, 0);
      // response with nothing outstanding
      bus.mem_resp_v_i = 1'b1;
      #1;
      chk("t5_empty_yumi", bus.mem_resp_yumi_o, 0);
      chk("t5_empty_v", {bus.resp1_v_o, bus.resp0_v_o}, 0);
      chk("t5_err_before", err, 0);
      tick();
      chk("t5_err_set", err, 1);
      resp_clear();
      tick();
      chk("t5_err_sticky", err, 1);
      // yumi from the non-head requester
      reset_n_i = 1'b0;
      #1;
      reset_n_i = 1'b1;
      issue(1'b1, 1'b0, 1'b0, 11);
      idle();
      bus.mem_resp_v_i = 1'b1;
      bus.resp1_yumi_i = 1'b1;
      #1;
      chk("t6_wrong_yumi", bus.mem_resp_yumi_o, 0);
      chk("t6_head_v", bus.resp0_v_o, 1);
      tick();
      resp_clear();
      chk("t6_err", err, 1);
      chk("t6_outstanding", outstanding, 1);
      respond();
      chk("t6_drained", outstanding, 0);
      // reset with three in flight
      for (int k = 12; k < 15; k++) issue(1'b1, 1'b0, 1'b0, k);
      chk("t7_outstanding", outstanding, 3);
      bus.cmd0_v_i = 1'b1;
      bus.cmd1_v_i = 1'b1;
      bus.mem_resp_v_i = 1'b1;
      bus.resp0_yumi_i = 1'b1;
      reset_n_i = 1'b0;
      #1;
      chk("t7_rst_outstanding", outstanding, 0);
      chk("t7_rst_err", err, 0);
      chk("t7_rst_v_rdy", {bus.mem_cmd_v_o, bus.cmd0_ready_o, bus.cmd1_ready_o,
                           bus.resp0_v_o, bus.resp1_v_o, bus.mem_resp_yumi_o}, 0);
      sb.delete();
      tick();
      resp_clear();
      reset_n_i = 1'b1;
      issue(1'b1, 1'b1, 1'b0, 15);
      chk("t7_post_outstanding", outstanding, 1);
      idle();
      respond();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
